// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op-select codes, op classes and sequencer states.
package fpu_pkg;

   // Op-select codes shared with the FPU decoder; any other code is a
   // single-cycle operation (sign-inject, move, compare, classify).
   localparam logic [4:0] FPU_ADD    = 5'd0;
   localparam logic [4:0] FPU_SUB    = 5'd1;
   localparam logic [4:0] FPU_MUL    = 5'd2;
   localparam logic [4:0] FPU_DIV    = 5'd3;
   localparam logic [4:0] FPU_SQRT   = 5'd4;
   localparam logic [4:0] FPU_CVT_WS = 5'd5;
   localparam logic [4:0] FPU_CVT_SW = 5'd6;

   // FIXED: known latency, VAR: wait for fpu_done, COMB: bypasses the sequencer.
   typedef enum logic [1:0] {
      CLS_COMB  = 2'd0,
      CLS_FIXED = 2'd1,
      CLS_VAR   = 2'd2
   } fpu_class_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WB    = 2'd3
   } fpu_state_e;

endpackage

// File: rtl/fpu_op_class.sv
// Combinational op-select decode into op class and fixed latency.
module fpu_op_class
   import fpu_pkg::*;
#(
   parameter int LAT_ADD = 3,
   parameter int LAT_MUL = 4,
   parameter int LAT_CVT = 2,
   parameter int CNT_W   = 6
) (
   input  logic [4:0]       sel_i,
   output fpu_class_e       cls_o,
   output logic [CNT_W-1:0] lat_o
);

   // Latency is only meaningful for FIXED ops; it stays zero otherwise.
   always_comb begin
      cls_o = CLS_COMB;
      lat_o = '0;
      case (sel_i)
         FPU_ADD, FPU_SUB: begin
            cls_o = CLS_FIXED;
            lat_o = CNT_W'(LAT_ADD);
         end
         FPU_MUL: begin
            cls_o = CLS_FIXED;
            lat_o = CNT_W'(LAT_MUL);
         end
         FPU_CVT_WS, FPU_CVT_SW: begin
            cls_o = CLS_FIXED;
            lat_o = CNT_W'(LAT_CVT);
         end
         FPU_DIV, FPU_SQRT: begin
            cls_o = CLS_VAR;
         end
         default: begin
            cls_o = CLS_COMB;
         end
      endcase
   end

endmodule

// File: rtl/fpu_issue_sequencer.sv
// Sequences multi-cycle FPU ops from EX: stalls the pipe, drives start/kill,
// and emits a one-cycle writeback strobe with the latched rd.
// Handshake: an op is accepted in the IDLE cycle where ex_valid is high, the
// op is not single-cycle and flush is low; stall stays high from that cycle
// until the op finishes, so EX holds the instruction exactly while stalled.
module fpu_issue_sequencer
   import fpu_pkg::*;
#(
   parameter int LAT_ADD = 3,
   parameter int LAT_MUL = 4,
   parameter int LAT_CVT = 2,
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ex_valid,
   input  logic [4:0] ex_sel,
   input  logic [4:0] ex_rd,
   input  logic       ex_regwritef,
   input  logic [2:0] ex_rm,
   input  logic       flush,
   input  logic       fpu_done,
   output logic       stall,
   output logic       fpu_start,
   output logic [4:0] fpu_sel,
   output logic [2:0] fpu_rm,
   output logic       fpu_kill,
   output logic       wb_valid,
   output logic [4:0] wb_rd,
   output logic       wb_we,
   output logic [4:0] busy_rd,
   output logic       busy,
   output logic       timeout_err
);

   localparam int MAX_AM = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
   localparam int MAX_CT = (LAT_CVT > TIMEOUT) ? LAT_CVT : TIMEOUT;
   localparam int MAX_L  = (MAX_AM > MAX_CT) ? MAX_AM : MAX_CT;
   localparam int CNT_W  = $clog2(MAX_L);

   fpu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       sel_q, sel_d;
   logic [4:0]       rd_q, rd_d;
   logic [2:0]       rm_q, rm_d;
   logic             we_q, we_d;
   logic             terr_q, terr_d;

   fpu_class_e       cls;
   logic [CNT_W-1:0] lat;
   logic             issue;

   fpu_op_class #(
      .LAT_ADD (LAT_ADD),
      .LAT_MUL (LAT_MUL),
      .LAT_CVT (LAT_CVT),
      .CNT_W   (CNT_W)
   ) u_op_class (
      .sel_i (ex_sel),
      .cls_o (cls),
      .lat_o (lat)
   );

   assign busy        = (state_q == ST_COUNT) || (state_q == ST_WAIT);
   assign stall       = issue || busy;
   assign busy_rd     = busy ? rd_q : 5'd0;
   // The FPU sees the op select and rounding mode together with fpu_start.
   assign fpu_sel     = issue ? ex_sel : sel_q;
   assign fpu_rm      = issue ? ex_rm : rm_q;
   assign wb_rd       = wb_valid ? rd_q : 5'd0;
   assign wb_we       = wb_valid && we_q;
   assign timeout_err = terr_q;

   // Next-state, latch updates and one-cycle pulses; flush has priority
   // over fpu_done and counter expiry.
   always_comb begin
      issue     = (state_q == ST_IDLE) && ex_valid && (cls != CLS_COMB) && !flush;
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      rd_d      = rd_q;
      rm_d      = rm_q;
      we_d      = we_q;
      terr_d    = terr_q;
      fpu_start = 1'b0;
      fpu_kill  = 1'b0;
      wb_valid  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (issue) begin
               fpu_start = 1'b1;
               sel_d     = ex_sel;
               rd_d      = ex_rd;
               rm_d      = ex_rm;
               we_d      = ex_regwritef;
               if (cls == CLS_FIXED) begin
                  // Issue cycle plus the WB cycle account for two of LAT.
                  state_d = ST_COUNT;
                  cnt_d   = lat - CNT_W'(2);
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_W'(TIMEOUT - 1);
               end
            end
         end
         ST_COUNT: begin
            if (flush) begin
               fpu_kill = 1'b1;
               state_d  = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_WB;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (flush) begin
               fpu_kill = 1'b1;
               state_d  = ST_IDLE;
            end else if (fpu_done) begin
               state_d = ST_WB;
            end else if (cnt_q == '0) begin
               fpu_kill = 1'b1;
               terr_d   = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_WB: begin
            wb_valid = !flush;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counter and latched operand fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         rd_q    <= '0;
         rm_q    <= '0;
         we_q    <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         rd_q    <= rd_d;
         rm_q    <= rm_d;
         we_q    <= we_d;
         terr_q  <= terr_d;
      end
   end

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Bench for fpu_issue_sequencer: scenario table, hand sequences, random run
// against a transaction-timing reference model.
module tb_fpu_issue_sequencer;
   import fpu_pkg::*;

   localparam int LAT_ADD = 3;
   localparam int LAT_MUL = 4;
   localparam int LAT_CVT = 2;
   localparam int TIMEOUT = 64;

   logic       clk;
   logic       rst_n;
   logic       ex_valid;
   logic [4:0] ex_sel;
   logic [4:0] ex_rd;
   logic       ex_regwritef;
   logic [2:0] ex_rm;
   logic       flush;
   logic       fpu_done;
   logic       stall;
   logic       fpu_start;
   logic [4:0] fpu_sel;
   logic [2:0] fpu_rm;
   logic       fpu_kill;
   logic       wb_valid;
   logic [4:0] wb_rd;
   logic       wb_we;
   logic [4:0] busy_rd;
   logic       busy;
   logic       timeout_err;

   fpu_issue_sequencer #(
      .LAT_ADD (LAT_ADD),
      .LAT_MUL (LAT_MUL),
      .LAT_CVT (LAT_CVT),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_valid     (ex_valid),
      .ex_sel       (ex_sel),
      .ex_rd        (ex_rd),
      .ex_regwritef (ex_regwritef),
      .ex_rm        (ex_rm),
      .flush        (flush),
      .fpu_done     (fpu_done),
      .stall        (stall),
      .fpu_start    (fpu_start),
      .fpu_sel      (fpu_sel),
      .fpu_rm       (fpu_rm),
      .fpu_kill     (fpu_kill),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_we        (wb_we),
      .busy_rd      (busy_rd),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int now      = 0;

   // ---------------- reference model ----------------
   // An op is described by its absolute writeback cycle (fixed ops) or a
   // timeout deadline (variable ops); no counters or states are modelled.
   bit         m_active;
   bit         m_var;
   int         m_wb_cycle;
   int         m_deadline;
   bit         m_terr;
   logic [4:0] m_rd;
   logic [4:0] m_sel;
   logic [2:0] m_rm;
   logic       m_we;

   // observations of the last step, used by the scenario runner
   logic       obs_wb, obs_kill, obs_stall, obs_start;
   logic [4:0] obs_wbrd;

   // 0: single-cycle op, -1: variable latency, else fixed latency
   function automatic int op_lat(input logic [4:0] s);
      case (s)
         FPU_ADD, FPU_SUB:       return LAT_ADD;
         FPU_MUL:                return LAT_MUL;
         FPU_CVT_WS, FPU_CVT_SW: return LAT_CVT;
         FPU_DIV, FPU_SQRT:      return -1;
         default:                return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_active   = 1'b0;
      m_var      = 1'b0;
      m_wb_cycle = -1;
      m_deadline = -1;
      m_terr     = 1'b0;
      m_rd       = '0;
      m_sel      = '0;
      m_rm       = '0;
      m_we       = 1'b0;
      now        = 0;
   endtask

   task automatic check_vec(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle=%0d got=%h expected=%h", name, now, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s got=%0d expected=%0d", name, act, exp);
   endtask

   function automatic logic [24:0] all_outs();
      return {stall, fpu_start, fpu_sel, fpu_rm, fpu_kill, wb_valid, wb_rd, wb_we,
              busy_rd, busy, timeout_err};
   endfunction

   // ---------------- driver ----------------
   task automatic do_reset();
      ex_valid = 0; ex_sel = '0; ex_rd = '0; ex_regwritef = 0; ex_rm = '0;
      flush = 0; fpu_done = 0;
      rst_n = 1'b0;
      #3;
      check_vec("reset_outputs", {7'd0, all_outs()}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // One cycle: drive inputs away from the edge, compare, advance the model.
   task automatic step(input logic v, input logic [4:0] s, input logic [4:0] rd,
                       input logic we, input logic [2:0] rm, input logic fl, input logic dn);
      logic       e_stall, e_start, e_kill, e_wb, e_busy, e_terr;
      logic [4:0] e_brd;
      logic [24:0] e_vec, a_vec;
      int         lat;
      @(negedge clk);
      ex_valid = v; ex_sel = s; ex_rd = rd; ex_regwritef = we; ex_rm = rm;
      flush = fl; fpu_done = dn;
      #1;
      e_stall = 0; e_start = 0; e_kill = 0; e_wb = 0; e_busy = 0; e_brd = '0;
      e_terr = m_terr;
      if (m_active && now == m_wb_cycle) begin
         e_wb     = !fl;
         m_active = 1'b0;
      end else if (m_active) begin
         e_stall = 1; e_busy = 1; e_brd = m_rd;
         if (fl) begin
            e_kill = 1; m_active = 1'b0;
         end else if (m_var && dn) begin
            m_wb_cycle = now + 1;
         end else if (m_var && now == m_deadline) begin
            e_kill = 1; m_terr = 1'b1; m_active = 1'b0;
         end
      end else begin
         lat = op_lat(s);
         if (v && lat != 0 && !fl) begin
            e_start = 1; e_stall = 1;
            m_active = 1'b1; m_rd = rd; m_we = we; m_sel = s; m_rm = rm;
            m_var = (lat < 0);
            if (lat < 0) begin
               m_wb_cycle = -1;
               m_deadline = now + TIMEOUT;
            end else begin
               m_wb_cycle = now + lat;
            end
         end
      end
      e_vec = {e_stall, e_start, e_kill, e_wb, e_busy, e_terr, e_brd,
               e_wb ? m_rd : 5'd0, e_wb & m_we,
               e_busy ? m_sel : 5'd0, e_busy ? m_rm : 3'd0};
      a_vec = {stall, fpu_start, fpu_kill, wb_valid, busy, timeout_err, busy_rd,
               wb_valid ? wb_rd : 5'd0, wb_valid & wb_we,
               busy ? fpu_sel : 5'd0, busy ? fpu_rm : 3'd0};
      check_vec("cycle_model", {7'd0, a_vec}, {7'd0, e_vec});
      obs_wb = wb_valid; obs_kill = fpu_kill; obs_stall = stall; obs_start = fpu_start;
      obs_wbrd = wb_rd;
      now++;
   endtask

   // ---------------- scenario table ----------------
   typedef struct {
      logic [4:0] sel;
      int         done_at;
      int         flush_at;
      int         exp_wb_at;
      int         exp_kill_at;
      int         exp_stall_last;
      int         exp_starts;
      int         exp_terr;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int wb_at, kill_at, stall_last, starts, wb_cnt;
      int wb1, wb2, st2;
      logic [4:0] wbrd, rd1, rd2;

      rst_n = 1'b0;
      model_reset();

      vecs[0]  = '{FPU_ADD,    -1, -1,  3, -1,  2, 1, 0};
      vecs[1]  = '{FPU_MUL,    -1, -1,  4, -1,  3, 1, 0};
      vecs[2]  = '{FPU_CVT_WS, -1, -1,  2, -1,  1, 1, 0};
      vecs[3]  = '{FPU_SUB,    -1, -1,  3, -1,  2, 1, 0};
      vecs[4]  = '{FPU_DIV,    10, -1, 11, -1, 10, 1, 0};
      vecs[5]  = '{FPU_SQRT,   -1, -1, -1, 64, 64, 1, 1};
      vecs[6]  = '{FPU_MUL,    -1,  2, -1,  2,  2, 1, 0};
      vecs[7]  = '{FPU_DIV,     5,  5, -1,  5,  5, 1, 0};
      vecs[8]  = '{FPU_ADD,    -1,  3, -1, -1,  2, 1, 0};
      vecs[9]  = '{5'd8,       -1, -1, -1, -1, -1, 0, 0};
      vecs[10] = '{FPU_DIV,     1, -1,  2, -1,  1, 1, 0};
      vecs[11] = '{FPU_CVT_SW, -1,  1, -1,  1,  1, 1, 0};

      for (int i = 0; i < 12; i++) begin
         do_reset();
         wb_at = -1; kill_at = -1; stall_last = -1; starts = 0; wb_cnt = 0; wbrd = '0;
         for (int c = 0; c < 70; c++) begin
            step(c == 0, vecs[i].sel, 5'(i + 3), 1'b1, 3'(i), c == vecs[i].flush_at,
                 c == vecs[i].done_at);
            if (obs_wb) begin wb_at = c; wb_cnt++; wbrd = obs_wbrd; end
            if (obs_kill) kill_at = c;
            if (obs_stall) stall_last = c;
            if (obs_start) starts++;
         end
         check_int($sformatf("row%0d_wb_at", i), wb_at, vecs[i].exp_wb_at);
         check_int($sformatf("row%0d_wb_count", i), wb_cnt, (vecs[i].exp_wb_at >= 0) ? 1 : 0);
         check_int($sformatf("row%0d_kill_at", i), kill_at, vecs[i].exp_kill_at);
         check_int($sformatf("row%0d_stall_last", i), stall_last, vecs[i].exp_stall_last);
         check_int($sformatf("row%0d_starts", i), starts, vecs[i].exp_starts);
         check_int($sformatf("row%0d_terr", i), int'(timeout_err), vecs[i].exp_terr);
         if (vecs[i].exp_wb_at >= 0)
            check_int($sformatf("row%0d_wb_rd", i), int'(wbrd), i + 3);
      end

      // Back-to-back FADDs: EX holds the first until WB, second issues next cycle.
      do_reset();
      wb1 = -1; wb2 = -1; rd1 = '0; rd2 = '0; starts = 0;
      for (int c = 0; c < 12; c++) begin
         step(c <= 4, FPU_ADD, (c <= 3) ? 5'd1 : 5'd2, 1'b1, 3'd0, 1'b0, 1'b0);
         if (obs_start) starts++;
         if (obs_wb && wb1 < 0) begin wb1 = c; rd1 = obs_wbrd; end
         else if (obs_wb) begin wb2 = c; rd2 = obs_wbrd; end
      end
      check_int("b2b_starts", starts, 2);
      check_int("b2b_wb1", wb1, 3);
      check_int("b2b_wb2", wb2, 7);
      check_int("b2b_wb_gap", wb2 - wb1, 4);
      check_int("b2b_rd1", int'(rd1), 1);
      check_int("b2b_rd2", int'(rd2), 2);

      // FMUL flushed at T+2, then an FADD accepted at T+3.
      do_reset();
      kill_at = -1; st2 = -1; wb_at = -1; wb_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         step((c == 0) || (c == 3), (c < 3) ? FPU_MUL : FPU_ADD, 5'd7, 1'b1, 3'd2,
              c == 2, 1'b0);
         if (obs_kill) kill_at = c;
         if (obs_start && c > 0) st2 = c;
         if (obs_wb) begin wb_at = c; wb_cnt++; end
      end
      check_int("flush_kill_at", kill_at, 2);
      check_int("flush_restart_at", st2, 3);
      check_int("flush_wb_at", wb_at, 6);
      check_int("flush_wb_count", wb_cnt, 1);

      // Asynchronous reset in the middle of a DIV wait.
      do_reset();
      step(1'b1, FPU_DIV, 5'd9, 1'b1, 3'd1, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) step(1'b0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      check_int("pre_reset_busy", int'(busy), 1);
      do_reset();

      // Random traffic against the model.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         step(1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 5'($urandom_range(7, 31)) : 5'($urandom_range(0, 6)),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              $urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
